// File: rtl/arb_mux_rr_pkg.sv
// Shared definitions for the round-robin valid/ready multiplexer: defaults, lock FSM states, helpers.
// The optional packet lock is enabled by defining ARB_MUX_LOCK_EN.
package arb_mux_rr_pkg;

  localparam int DEF_W = 32;
  localparam int DEF_N = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Next pointer after index idx, wrapping from n-1 back to 0.
  function automatic int ptr_wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

  function automatic logic sel_in_range(input int sel, input int n);
    return sel < n;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping N-1 -> 0.
module rr_grant
  import arb_mux_rr_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx[SELW-1:0]]) begin
        grant[idx[SELW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-way W-bit round-robin mux with per-input valid/ready, select override and one output register.
// Define ARB_MUX_LOCK_EN to add in_last and hold the grant on one input until its packet ends.
module arb_mux_rr
  import arb_mux_rr_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]    in_last,
`endif
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    lane [N];
  logic [W-1:0]    data_reg;
  logic [SELW-1:0] sel_reg;
  logic [SELW-1:0] ptr_reg;
  logic            valid_reg;
  logic            load;
  logic            force_hit;
  logic            force_used;
  logic            locked;
  logic            last_beat;
  logic            xfer;
  logic [SELW-1:0] lock_sel;
  logic [SELW-1:0] xfer_idx;
  logic [N-1:0]    rr_gnt;
  logic [N-1:0]    grant;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = in_data[gi*W +: W];
    end
  endgenerate

  rr_grant #(.N(N)) u_rr_grant (
    .req   (in_valid),
    .ptr   (ptr_reg),
    .grant (rr_gnt)
  );

  assign load      = !valid_reg | out_ready;
  assign force_hit = sel_in_range(int'(force_sel), N) && in_valid[force_sel];

  // Priority: an open packet lock beats the override, which beats round-robin.
  always_comb begin
    grant      = rr_gnt;
    force_used = 1'b0;
    if (locked) begin
      grant           = '0;
      grant[lock_sel] = in_valid[lock_sel];
    end else if (force_en) begin
      force_used = 1'b1;
      grant      = '0;
      if (force_hit) begin
        grant[force_sel] = 1'b1;
      end
    end
  end

  assign in_ready = grant & {N{load}};
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    xfer_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        xfer_idx = SELW'(i);
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  lock_state_t     state_reg;
  lock_state_t     state_next;
  logic [SELW-1:0] lock_sel_reg;

  assign last_beat = in_last[xfer_idx];
  assign lock_sel  = lock_sel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lock_sel_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && xfer) begin
        lock_sel_reg <= xfer_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (xfer && !last_beat) state_next = LOCKED;
      LOCKED:  if (xfer && last_beat)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    locked = (state_reg == LOCKED);
  end
`else
  assign last_beat = 1'b1;
  assign lock_sel  = '0;
  assign locked    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      ptr_reg   <= '0;
    end else if (xfer) begin
      data_reg  <= lane[xfer_idx];
      sel_reg   <= xfer_idx;
      valid_reg <= 1'b1;
      if (!force_used && last_beat) begin
        ptr_reg <= SELW'(ptr_wrap_inc(int'(xfer_idx), N));
      end
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_data  = data_reg;
  assign out_sel   = sel_reg;
  assign out_valid = valid_reg;

endmodule
